// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- RV32I instruction fetch / program-counter stage.
//
// Owns the PC. It fetches one instruction word from instruction memory over a
// valid/ready handshake and holds it for one execute window. During that
// window decode and the control unit look at it. When the window closes, the
// PC moves to the next-PC value selected by the control-unit signals.
//
// Handshake (imem): imem_req is the request valid and imem_addr the address.
// Both are stable while the request is outstanding. The request completes on
// the first rising edge with imem_ready = 1, and imem_rdata is captured on that
// edge. imem_ready is ignored whenever no request is outstanding.
//
// Ports:
//   clk, reset            core clock (rising edge), async active-high reset
//   imem_req/imem_addr    fetch request valid / address (= pc)
//   imem_ready/imem_rdata fetch completion / instruction word
//   instr, instr_valid    registered instruction and its execute window
//   pc, pc_plus4          address of instr and pc + 4 (combinational)
//   Branch, JAL, JALR     control-unit outputs, sampled only in the window
//   branch_taken, imm     branch comparison result, sign-extended immediate
//   alu_result            rs1 + imm, the JALR target
//   stall                 holds the execute window open
//   misaligned            one-cycle pulse after a trapped misaligned target
//
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned next-PC
// values to TRAP_PC and pulse misaligned. Without the macro, misaligned is
// tied 0 and the next PC is loaded unchanged.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        JAL,
  input  logic        JALR,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        stall,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        boot_armed_q;   // set by the first edge after reset release
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic [31:0] pc_load_value;
  logic        pc_load;
  logic        instr_load;

  // alu_result[0] is always cleared by the JALR target rule.
  logic        unused_alu_lsb;
  assign unused_alu_lsb = alu_result[0];

  // ---------------------------------------------------------------------------
  // State register. boot_armed_q makes BOOT span one full cycle after reset
  // deasserts, so the first request appears after the second edge. This holds
  // even when reset is released just before an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      boot_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_armed_q <= 1'b1;
    end
  end

  // Next-state and load enables.
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    case (state_q)
      BOOT: begin
        if (boot_armed_q) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ready) begin
          instr_load = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection. The if/else order is the priority. Branch is never
  // looked at when JAL or JALR is set, so an X on it cannot leak through.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (JALR) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (JAL) begin
      next_pc = pc_q + imm;
    end else if (Branch && branch_taken) begin
      next_pc = pc_q + imm;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;
  logic target_misaligned;

  assign target_misaligned = (next_pc[1:0] != 2'b00);
  assign pc_load_value     = target_misaligned ? TRAP_PC : next_pc;

  // misaligned is set on the EXEC exit edge. It is therefore high for exactly
  // the first FETCH cycle of the trap target, and the next edge clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= pc_load && target_misaligned;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign pc_load_value = next_pc;
  assign misaligned    = 1'b0;
`endif

  // PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= pc_load_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
    end else if (instr_load) begin
      instr_q <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The request, address and window flag are decoded only from the
  // state and pc registers, so they have no combinational input dependency.
  // Reset forces state_q to BOOT asynchronously, which drops imem_req at once.
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The reference model works one instruction at a time. It keeps the queue of
// expected fetch addresses and computes each next address from the
// control-flow rules. Outputs are sampled on the falling edge, and inputs are
// driven there too.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        JAL;
  logic        JALR;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        stall;
  logic        misaligned;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .Branch       (Branch),
    .JAL          (JAL),
    .JALR         (JALR),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .stall        (stall),
    .misaligned   (misaligned)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];     // expected fetch addresses, oldest first
  logic        exp_mis;      // expected misaligned in the next first FETCH cycle
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of the address the next instruction is fetched from.
  task automatic model_next(input logic [31:0] cur, input logic br,
                            input logic j, input logic jr, input logic tk,
                            input logic [31:0] imm_v, input logic [31:0] alu_v);
    logic [31:0] target;
    if (jr)              target = alu_v & 32'hFFFF_FFFE;
    else if (j)          target = cur + imm_v;
    else if (br && tk)   target = cur + imm_v;
    else                 target = cur + 32'd4;
`ifdef MISALIGN_TRAP_EN
    if (target[1:0] != 2'b00) begin
      exp_q.push_back(TRAP_PC);
      exp_mis = 1'b1;
    end else begin
      exp_q.push_back(target);
      exp_mis = 1'b0;
    end
`else
    exp_q.push_back(target);
    exp_mis = 1'b0;
`endif
  endtask

  // ---------------------------------------------------------------- driver
  // Entry: at a falling edge, with the DUT in its first FETCH cycle.
  // Exit: the same position, for the following instruction.
  task automatic run_instr(input int waits, input int stalls, input logic br,
                           input logic j, input logic jr, input logic tk,
                           input logic [31:0] imm_v, input logic [31:0] alu_v);
    logic [31:0] cur;
    logic [31:0] word;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, cur);
    check("fetch_valid", 32'(instr_valid), 32'd0);
    check("mis_first", 32'(misaligned), 32'(exp_mis));
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, cur);
      check("wait_mis", 32'(misaligned), 32'd0);
    end
    word       = $urandom;
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    // In EXEC imem_ready and imem_rdata must be ignored, so drive them randomly.
    imem_ready   = 1'($urandom_range(0, 1));
    imem_rdata   = $urandom;
    Branch       = (j || jr) ? 1'bx : br;
    JAL          = j;
    JALR         = jr;
    branch_taken = tk;
    imm          = imm_v;
    alu_result   = alu_v;
    for (int i = 0; i <= stalls; i++) begin
      stall = (i < stalls);
      check("exec_valid", 32'(instr_valid), 32'd1);
      check("exec_req", 32'(imem_req), 32'd0);
      check("exec_instr", instr, word);
      check("exec_pc", pc, cur);
      check("exec_pc4", pc_plus4, cur + 32'd4);
      if (i == stalls) model_next(cur, br, j, jr, tk, imm_v, alu_v);
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    stall  = 1'b0;
    Branch = 1'b0;
    JAL    = 1'b0;
    JALR   = 1'b0;
    imem_ready = 1'b1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    v = {{20{1'b0}}, 10'($urandom_range(0, 1023)), 2'b00} - 32'd2048;
    if ($urandom_range(0, 7) == 0) v = v + 32'd2;   // occasional misaligned
    return v;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] cur;
    int          kind;
    reset = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = NOP;
    Branch = 1'b0; JAL = 1'b0; JALR = 1'b0; branch_taken = 1'b0;
    imm = 32'd0; alu_result = 32'd0; stall = 1'b0;
    exp_mis = 1'b0;

    // Reset values
    #2;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_pc", pc, RESET_PC);
    check("rst_pc4", pc_plus4, RESET_PC + 32'd4);
    check("rst_instr", instr, NOP);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);                       // one edge after release: still BOOT
    check("boot_req", 32'(imem_req), 32'd0);
    check("boot_instr", instr, NOP);
    @(negedge clk);                       // second edge: first request
    exp_q.push_back(RESET_PC);

    // NOP stream from 0 up to 0x40, no waits, no stalls
    for (int k = 0; k < 16; k++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    // Branch taken at 0x40 with imm -16: next fetch from 0x30
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd0);
    check("br_taken_addr", imem_addr, 32'h30);
    for (int k = 0; k < 4; k++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    // Branch not taken at 0x40: next fetch from 0x44
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
    check("br_nt_addr", imem_addr, 32'h44);
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);   // back to 0x40
    // JALR at 0x40 to 0x1235: the LSB is cleared
    run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_1235);
    check("jalr_addr", imem_addr, 32'h1234);
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40 - 32'h1234, 32'd0);
    // JAL at 0x40 with imm 8: next fetch from 0x48
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
    check("jal_addr", imem_addr, 32'h48);
    // 3 wait cycles and 2 stall cycles
    run_instr(3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("ws_addr", imem_addr, 32'h4C);
    // Wrap-around from 0xFFFF_FFFC to 0
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC - 32'h4C, 32'd0);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("wrap_addr", imem_addr, 32'h0);
    // JAL at 0 with imm 6: misaligned target
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("trap_addr", imem_addr, TRAP_PC);
    check("trap_mis", 32'(misaligned), 32'd1);
`else
    check("mis_addr", imem_addr, 32'h6);
    check("mis_low", 32'(misaligned), 32'd0);
`endif

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 4);
      cur  = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
      run_instr($urandom_range(0, 2), $urandom_range(0, 2),
                kind == 1 || kind == 2, kind == 3, kind == 4, kind == 1,
                rand_imm(), cur + rand_imm());
    end

    // Reset in the middle of FETCH while imem_ready = 1
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    #1 reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_addr", imem_addr, RESET_PC);
    check("mid_rst_instr", instr, NOP);
    @(negedge clk);
    check("mid_rst_instr2", instr, NOP);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    exp_mis = 1'b0;
    for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("post_rst_addr", imem_addr, 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit, in case the stimulus block stalls.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage of the RV32I core. Owns the PC register and fetches instructions from instruction memory over a valid/ready handshake. Presents each instruction for one execute window to decode and the control unit, which drive the opcode-derived Branch/JAL/JALR signals. Computes the next PC from those signals, the branch comparison, the immediate and the ALU result.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, redirect target for a misaligned next PC (only with the macro).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals pc.
- imem_ready  input  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction under execution; bits [6:0] feed the control unit opcode.
- instr_valid  output  1  instr is in its execute window.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc + 4, used for the JAL/JALR writeback.
- Branch, JAL, JALR  input  1 each  control-unit outputs; sampled only while instr_valid = 1.
- branch_taken  input  1  branch comparison result.
- imm  input  32  sign-extended immediate.
- alu_result  input  32  rs1 + imm, the JALR target.
- stall  input  1  extends the execute window (data-memory wait).
- misaligned  output  1  one-cycle misaligned-target pulse.

## Operation
- States: BOOT, FETCH, EXEC.
- BOOT: entered on reset. Lasts exactly one cycle after reset deasserts, then moves to FETCH.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - On a clock edge with imem_ready = 1: instr <= imem_rdata, then move to EXEC.
  - With imem_ready = 0: hold the request with a stable address.
- EXEC:
  - instr_valid = 1 and instr is held stable.
  - stall = 1: remain in EXEC with pc unchanged.
  - stall = 0: pc <= next_pc, then move to FETCH.
- next_pc priority:
  - JALR = 1: {alu_result[31:1], 1'b0}.
  - else JAL = 1: pc + imm.
  - else Branch & branch_taken: pc + imm.
  - else: pc + 4.
  - Branch is don't-care whenever JAL or JALR is 1, including X.
- All address arithmetic is 32-bit modulo 2^32. pc = 32'hFFFF_FFFC falls through to 0. imm is not re-extended.
- imem_ready outside FETCH is ignored.
- reset in any state: immediate return to BOOT. A pending request is dropped, imem_req falls asynchronously, and no late imem_ready is captured.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, pc RESET_PC, pc_plus4 RESET_PC+4, instr 32'h0000_0013 (NOP), instr_valid 0, misaligned 0.
- First request: the cycle after BOOT, i.e. the second edge after reset deasserts.
- Minimum of 2 cycles per instruction: FETCH with imem_ready = 1, then EXEC with stall = 0. Each wait cycle adds 1, as does each stall cycle.
- imem_req, imem_addr and instr_valid are decoded from the state and pc registers only. No combinational path from any input to them.
- pc_plus4 is combinational from pc.

## Configuration
- MISALIGN_TRAP_EN defined:
  - If next_pc[1:0] != 0 on an EXEC exit: pc <= TRAP_PC instead of next_pc.
  - misaligned is registered high for exactly the first following FETCH cycle.
- Undefined:
  - misaligned is tied 0.
  - next_pc is loaded unchanged and used as imem_addr.

## Test plan
- Reset with RESET_PC=0, imem_ready held 1, NOP stream -> imem_req first high 2 edges after reset release; pc sequence 0,4,8 at one instruction per 2 cycles; instr_valid alternates 0/1.
- At pc=0x40, Branch=1, branch_taken=1, imm=0xFFFF_FFF0 -> next fetch address 0x30. With branch_taken=0 -> next fetch address 0x44.
- At pc=0x40, JALR=1, Branch=X, alu_result=0x0000_1235 -> next fetch address 0x1234, pc_plus4=0x44 during EXEC. JAL=1, imm=8 -> next fetch address 0x48.
- imem_ready low for 3 cycles, then stall high for 2 cycles -> imem_addr stable throughout; instr_valid high for 3 cycles; pc advances once.
- reset asserted mid-FETCH while imem_ready=1 -> imem_req drops immediately; pc=RESET_PC; instr stays NOP.
- With MISALIGN_TRAP_EN, JAL at pc=0 with imm=6 -> next fetch address 0x100 and misaligned pulses for 1 cycle. Without the macro -> next fetch address 0x6 and misaligned stays 0.
